// File: rtl/mem_sweep_ctrl.sv
// Fill / parallel-sweep / check controller for a 4-read, 1-write block RAM.
// Writes an address-derived pattern, reads it back four words per cycle and counts mismatches.
module mem_sweep_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int WID_MEM   = 1,
  parameter int DEPTH_MEM = 128,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WID_MEM-1:0] seed,
  output logic [ADDR_W-1:0]  raddr1,
  output logic [ADDR_W-1:0]  raddr2,
  output logic [ADDR_W-1:0]  raddr3,
  output logic [ADDR_W-1:0]  raddr4,
  output logic [ADDR_W-1:0]  waddr,
  output logic [WID_MEM-1:0] din,
  input  logic [WID_MEM-1:0] dout1,
  input  logic [WID_MEM-1:0] dout2,
  input  logic [WID_MEM-1:0] dout3,
  input  logic [WID_MEM-1:0] dout4,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_count,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int EXT_W = (WID_MEM > ADDR_W) ? WID_MEM : ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH_MEM - 1);
  localparam logic [ADDR_W-1:0] LAST_B = ADDR_W'(DEPTH_MEM - 4);

  function automatic logic [WID_MEM-1:0] pat(input logic [ADDR_W-1:0] a,
                                             input logic [WID_MEM-1:0] s);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(a);
    return ext[WID_MEM-1:0] ^ s;
  endfunction

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  chk_base_q;
  logic               valid_q;
  logic [WID_MEM-1:0] seed_q, seed_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;
  logic               start_prev_q;

  logic [WID_MEM-1:0] dout_a [4];
  logic [2:0]         mm;
  logic [CNT_W:0]     err_sum;
  logic [CNT_W-1:0]   err_acc;

  assign dout_a[0] = dout1;
  assign dout_a[1] = dout2;
  assign dout_a[2] = dout3;
  assign dout_a[3] = dout4;

  // Compare the group whose addresses went out one cycle ago; the sum saturates.
  always_comb begin
    mm = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (dout_a[k] != pat(chk_base_q + ADDR_W'(k), seed_q)) mm = mm + 3'd1;
    end
    err_sum = {1'b0, err_q} + (CNT_W+1)'(mm);
    err_acc = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    base_d  = base_q;
    seed_d  = seed_q;
    err_d   = valid_q ? err_acc : err_q;
    pass_d  = pass_q;
    raddr1  = '0;
    raddr2  = '0;
    raddr3  = '0;
    raddr4  = '0;
    waddr   = '0;
    din     = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !start_prev_q) begin
          seed_d  = seed;
          err_d   = '0;
          pass_d  = 1'b0;
          wptr_d  = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        busy   = 1'b1;
        waddr  = wptr_q;
        din    = pat(wptr_q, seed_q);
        wptr_d = wptr_q + ADDR_W'(1);
        if (wptr_q == LAST_A) begin
          wptr_d  = '0;
          base_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // The RAM writes every cycle, so keep rewriting the last word with its own value.
        busy   = 1'b1;
        waddr  = LAST_A;
        din    = pat(LAST_A, seed_q);
        raddr1 = base_q;
        raddr2 = base_q + ADDR_W'(1);
        raddr3 = base_q + ADDR_W'(2);
        raddr4 = base_q + ADDR_W'(3);
        base_d = base_q + ADDR_W'(4);
        if (base_q == LAST_B) begin
          base_d  = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        waddr   = LAST_A;
        din     = pat(LAST_A, seed_q);
        pass_d  = (err_d == '0);
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      base_q       <= '0;
      chk_base_q   <= '0;
      valid_q      <= 1'b0;
      seed_q       <= '0;
      err_q        <= '0;
      pass_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      base_q       <= base_d;
      chk_base_q   <= base_q;
      valid_q      <= (state_q == S_READ);
      seed_q       <= seed_d;
      err_q        <= err_d;
      pass_q       <= pass_d;
      start_prev_q <= start;
    end
  end

  assign pass      = pass_q;
  assign err_count = err_q;
  assign state_dbg = state_q;

endmodule
